// File: rtl/oam_dma.sv
// oam_dma: copies XFER_LEN bytes from {src_hi,8'h00} into OAM whenever the CPU writes the DMA register.
// Bus outputs are registered straight from the next-state decode so they always match the current state.
module oam_dma #(
   parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
   parameter logic [15:0] OAM_BASE     = 16'hFE00,
   parameter int          XFER_LEN     = 160
) (
   input  logic        I_CLK,
   input  logic        I_RESET_L,
   input  logic [15:0] I_CPU_ADDR,
   input  logic [7:0]  I_CPU_DATA,
   input  logic        I_CPU_WE_L,
   input  logic        I_CPU_RE_L,
   output logic [7:0]  O_CPU_DATA,
   output logic        O_CPU_SEL,
   output logic [15:0] O_ADDR,
   output logic        O_RE_L,
   output logic        O_WE_L,
   output logic [7:0]  O_DATA,
   output logic        O_DATA_OE,
   input  logic [7:0]  I_DATA,
   output logic        O_DMA_ACTIVE
);
   typedef enum logic [2:0] {IDLE, START, RD, RD_WAIT, WR, GAP} state_t;
   state_t      state_q, state_d;
   logic [7:0]  src_q, src_d, idx_q, idx_d, data_q, data_d, base_hi;
   logic [15:0] addr_q, addr_d;
   logic        re_q, re_d, we_q, we_d, oe_q, oe_d, act_q, act_d;
   logic        reg_hit, reg_wr, last;
   assign reg_hit    = I_CPU_ADDR == DMA_REG_ADDR;
   assign reg_wr     = reg_hit && !I_CPU_WE_L;
   assign O_CPU_SEL  = reg_hit && (!I_CPU_WE_L || !I_CPU_RE_L);
   assign O_CPU_DATA = reg_hit ? src_q : 8'h00;
   // Echo RAM E000-FDFF mirrors C000-DDFF.
   assign base_hi    = src_d >= 8'hE0 ? src_d - 8'h20 : src_d;
   assign last       = ({1'b0, idx_q} + 9'd1) == 9'(XFER_LEN);
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      data_d  = data_q;
      src_d   = reg_wr ? I_CPU_DATA : src_q;
      case (state_q)
         START:   state_d = RD;
         RD:      state_d = RD_WAIT;
         RD_WAIT: begin
            state_d = WR;
            data_d  = I_DATA;
         end
         WR:      state_d = GAP;
         GAP:     begin
            idx_d   = idx_q + 8'd1;
            state_d = last ? IDLE : RD;
         end
         default: state_d = IDLE;
      endcase
      if (reg_wr) begin
         state_d = START;
         idx_d   = 8'h00;
      end
      re_d   = !(state_d == RD || state_d == RD_WAIT);
      we_d   = state_d != WR;
      oe_d   = state_d == WR;
      act_d  = state_d != IDLE;
      addr_d = !re_d ? {base_hi, 8'h00} + {8'h00, idx_d} : !we_d ? OAM_BASE + {8'h00, idx_d} : 16'h0000;
   end
   always_ff @(posedge I_CLK or negedge I_RESET_L)
      if (!I_RESET_L) begin
         state_q <= IDLE;
         src_q   <= 8'h00;
         idx_q   <= 8'h00;
         data_q  <= 8'h00;
         addr_q  <= 16'h0000;
         re_q    <= 1'b1;
         we_q    <= 1'b1;
         oe_q    <= 1'b0;
         act_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         addr_q  <= addr_d;
         re_q    <= re_d;
         we_q    <= we_d;
         oe_q    <= oe_d;
         act_q   <= act_d;
      end
   assign O_ADDR       = addr_q;
   assign O_RE_L       = re_q;
   assign O_WE_L       = we_q;
   assign O_DATA       = data_q;
   assign O_DATA_OE    = oe_q;
   assign O_DMA_ACTIVE = act_q;
endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: directed test of oam_dma against a pattern memory and an OAM capture array.
module tb_oam_dma;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic [15:0] cpu_addr = 16'h0000;
   logic [7:0]  cpu_wdata = 8'h00;
   logic        cpu_we_l = 1'b1, cpu_re_l = 1'b1;
   logic [7:0]  cpu_rdata, o_data, i_data;
   logic        cpu_sel, o_re_l, o_we_l, o_oe, o_act;
   logic [15:0] o_addr;
   int          checks = 0, errors = 0;
   int          act_cnt, rd_cnt, wr_cnt, proto_err, seq_err;
   logic [15:0] first_rd, last_rd, first_wr, last_wr, prev_addr;
   logic        prev_re = 1'b1;
   logic [7:0]  oam [0:159];

   oam_dma dut (
      .I_CLK(clk), .I_RESET_L(rst_n), .I_CPU_ADDR(cpu_addr), .I_CPU_DATA(cpu_wdata),
      .I_CPU_WE_L(cpu_we_l), .I_CPU_RE_L(cpu_re_l), .O_CPU_DATA(cpu_rdata), .O_CPU_SEL(cpu_sel),
      .O_ADDR(o_addr), .O_RE_L(o_re_l), .O_WE_L(o_we_l), .O_DATA(o_data), .O_DATA_OE(o_oe),
      .I_DATA(i_data), .O_DMA_ACTIVE(o_act)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] pat(input logic [15:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h5A;
   endfunction

   assign i_data = o_re_l ? 8'h00 : pat(o_addr);

   always @(negedge clk) begin
      if (o_act) act_cnt++;
      if (!o_re_l && !o_we_l) proto_err++;
      if (o_oe && o_we_l) proto_err++;
      if (!o_re_l && !prev_re && o_addr !== prev_addr) proto_err++;
      if (!o_re_l && prev_re) begin
         if (rd_cnt == 0) first_rd = o_addr;
         else if (o_addr !== last_rd + 16'd1) seq_err++;
         last_rd = o_addr;
         rd_cnt++;
      end
      if (!o_we_l) begin
         if (wr_cnt == 0) first_wr = o_addr;
         else if (o_addr !== last_wr + 16'd1) seq_err++;
         last_wr = o_addr;
         wr_cnt++;
         if (o_addr >= 16'hFE00 && o_addr <= 16'hFE9F) oam[o_addr - 16'hFE00] = o_data;
      end
      prev_re   = o_re_l;
      prev_addr = o_addr;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #2;
   endtask

   task automatic clear();
      act_cnt = 0; rd_cnt = 0; wr_cnt = 0; proto_err = 0; seq_err = 0;
      first_rd = '0; last_rd = '0; first_wr = '0; last_wr = '0;
   endtask

   task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
      cpu_addr = a; cpu_wdata = d; cpu_we_l = 1'b0;
      step();
      cpu_we_l = 1'b1; cpu_addr = 16'h0000;
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 1000 && o_act; i++) step();
      chk(tag, {31'd0, o_act}, 32'd0);
   endtask

   function automatic int oam_bad(input logic [7:0] hi);
      int n = 0;
      for (int i = 0; i < 160; i++) if (oam[i] !== pat({hi, 8'(i)})) n++;
      return n;
   endfunction

   initial begin
      clear();
      step(); step();
      chk("rst_re", {31'd0, o_re_l}, 32'd1);
      chk("rst_we", {31'd0, o_we_l}, 32'd1);
      chk("rst_oe", {31'd0, o_oe}, 32'd0);
      chk("rst_act", {31'd0, o_act}, 32'd0);
      chk("rst_addr", {16'd0, o_addr}, 32'd0);
      chk("rst_data", {24'd0, o_data}, 32'd0);
      rst_n = 1'b1;
      step();
      cpu_addr = 16'hFF46; cpu_re_l = 1'b0; #1;
      chk("rst_src", {24'd0, cpu_rdata}, 32'd0);
      chk("sel_read", {31'd0, cpu_sel}, 32'd1);
      cpu_re_l = 1'b1;

      clear();
      cpu_addr = 16'hFF46; cpu_we_l = 1'b0; cpu_wdata = 8'hC1; #1;
      chk("sel_write", {31'd0, cpu_sel}, 32'd1);
      step();
      cpu_we_l = 1'b1; cpu_addr = 16'h0000;
      chk("c1_start_act", {31'd0, o_act}, 32'd1);
      chk("c1_start_re", {31'd0, o_re_l}, 32'd1);
      step();
      chk("c1_rd0_addr", {16'd0, o_addr}, 32'hC100);
      wait_idle("c1_done");
      chk("c1_active", act_cnt, 641);
      chk("c1_reads", rd_cnt, 160);
      chk("c1_writes", wr_cnt, 160);
      chk("c1_first_rd", {16'd0, first_rd}, 32'hC100);
      chk("c1_last_rd", {16'd0, last_rd}, 32'hC19F);
      chk("c1_first_wr", {16'd0, first_wr}, 32'hFE00);
      chk("c1_last_wr", {16'd0, last_wr}, 32'hFE9F);
      chk("c1_seq", seq_err, 0);
      chk("c1_protocol", proto_err, 0);
      chk("c1_oam", oam_bad(8'hC1), 0);

      clear();
      cpu_write(16'hFF46, 8'hE2);
      cpu_addr = 16'hFF46; cpu_re_l = 1'b0; #1;
      chk("e2_readback", {24'd0, cpu_rdata}, 32'hE2);
      cpu_re_l = 1'b1; cpu_addr = 16'h0000;
      wait_idle("e2_done");
      chk("e2_first_rd", {16'd0, first_rd}, 32'hC200);
      chk("e2_last_rd", {16'd0, last_rd}, 32'hC29F);
      chk("e2_reads", rd_cnt, 160);
      chk("e2_oam", oam_bad(8'hC2), 0);

      clear();
      cpu_write(16'hFF46, 8'hC0);
      for (int i = 0; i < 1000 && rd_cnt < 51; i++) step();
      chk("rt_reached_idx50", rd_cnt, 51);
      chk("rt_idx50_addr", {16'd0, last_rd}, 32'hC032);
      clear();
      cpu_write(16'hFF46, 8'hD0);
      chk("rt_start_act", {31'd0, o_act}, 32'd1);
      chk("rt_start_strobes", {30'd0, o_re_l, o_we_l}, 32'd3);
      step();
      chk("rt_rd_strobe", {31'd0, o_re_l}, 32'd0);
      chk("rt_rd_addr", {16'd0, o_addr}, 32'hD000);
      wait_idle("rt_done");
      chk("rt_active", act_cnt, 641);
      chk("rt_writes", wr_cnt, 160);
      chk("rt_oam", oam_bad(8'hD0), 0);
      chk("rt_protocol", proto_err, 0);

      clear();
      cpu_write(16'hFF46, 8'hC3);
      for (int i = 0; i < 1000 && wr_cnt < 81; i++) step();
      chk("rs_reached_wr80", {16'd0, last_wr}, 32'hFE50);
      chk("rs_in_wr", {31'd0, o_we_l}, 32'd0);
      rst_n = 1'b0; #1;
      chk("rs_we", {31'd0, o_we_l}, 32'd1);
      chk("rs_re", {31'd0, o_re_l}, 32'd1);
      chk("rs_oe", {31'd0, o_oe}, 32'd0);
      chk("rs_act", {31'd0, o_act}, 32'd0);
      cpu_addr = 16'hFF46; cpu_re_l = 1'b0; #1;
      chk("rs_src", {24'd0, cpu_rdata}, 32'd0);
      cpu_re_l = 1'b1; cpu_addr = 16'h0000;
      step();
      rst_n = 1'b1;
      clear();
      for (int i = 0; i < 40; i++) step();
      chk("rs_no_reads", rd_cnt, 0);
      chk("rs_no_writes", wr_cnt, 0);
      chk("rs_no_active", act_cnt, 0);

      clear();
      cpu_addr = 16'hFF45; cpu_wdata = 8'h77; cpu_we_l = 1'b0; #1;
      chk("ff45_sel", {31'd0, cpu_sel}, 32'd0);
      step();
      cpu_addr = 16'hFF47; #1;
      chk("ff47_sel", {31'd0, cpu_sel}, 32'd0);
      step();
      cpu_we_l = 1'b1;
      for (int i = 0; i < 20; i++) step();
      chk("wrong_addr_active", act_cnt, 0);
      chk("wrong_addr_reads", rd_cnt, 0);
      cpu_addr = 16'hFF46; cpu_re_l = 1'b0; #1;
      chk("wrong_addr_src", {24'd0, cpu_rdata}, 32'd0);
      cpu_re_l = 1'b1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
